touch_int_conditioner: RTL and testbench



---
 rtl/touch_int_conditioner.sv | 188 ++++++++++++++++++
 tb/tb_touch_int_conditioner.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/touch_int_conditioner.sv
// Conditions the raw active-low touch-controller interrupt before it reaches
// the touch-interrupt PIO: synchronises the pin, rejects short low glitches,
// debounces press and release, and stretches each accepted touch into a
// minimum-width low pulse. Diagnostic counters track accepted presses and
// rejected glitches.
module touch_int_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500,
    parameter int STRETCH_CYCLES  = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        touch_int_n,
    input  logic        enable,
    input  logic        event_count_clr,
    output logic        int_out,
    output logic        busy,
    output logic [15:0] event_count,
    output logic [7:0]  glitch_count
);

    localparam int QW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SW = $clog2(STRETCH_CYCLES + 1);
    localparam logic [QW-1:0] QUAL_LAST   = QW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] STRETCH_MAX = SW'(STRETCH_CYCLES);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        QUAL_LOW  = 2'd1,
        ASSERT    = 2'd2,
        QUAL_HIGH = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   s_in_s;
    state_t                 state_r;
    logic [QW-1:0]          qual_cnt_r;
    logic [SW-1:0]          stretch_cnt_r;
    logic                   int_out_r;
    logic                   busy_r;
    logic [15:0]            event_count_r;
    logic [7:0]             glitch_count_r;
    logic                   accept_s;
    logic                   glitch_s;

    // Synchroniser chain: the raw pin feeds the first flop directly; idles high.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], touch_int_n};
        end
    end

    assign s_in_s = sync_r[SYNC_STAGES-1];

    // Decode the press-accept and glitch-reject events for this cycle.
    always_comb begin
        accept_s = 1'b0;
        glitch_s = 1'b0;
        if (enable) begin
            case (state_r)
                IDLE: begin
                    accept_s = ~s_in_s & (DEBOUNCE_CYCLES == 1);
                end
                QUAL_LOW: begin
                    accept_s = ~s_in_s & (qual_cnt_r == QUAL_LAST);
                    glitch_s = s_in_s;
                end
                default: begin
                    accept_s = 1'b0;
                    glitch_s = 1'b0;
                end
            endcase
        end else begin
            accept_s = 1'b0;
            glitch_s = 1'b0;
        end
    end

    // Conditioning FSM with registered int_out and busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            qual_cnt_r    <= {QW{1'b0}};
            stretch_cnt_r <= {SW{1'b0}};
            int_out_r     <= 1'b1;
            busy_r        <= 1'b0;
        end else if (!enable) begin
            // Pulses in progress are dropped silently; counters are untouched.
            state_r       <= IDLE;
            qual_cnt_r    <= {QW{1'b0}};
            stretch_cnt_r <= {SW{1'b0}};
            int_out_r     <= 1'b1;
            busy_r        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r       <= ASSERT;
                        stretch_cnt_r <= {SW{1'b0}};
                        int_out_r     <= 1'b0;
                        busy_r        <= 1'b1;
                    end else if (!s_in_s) begin
                        state_r    <= QUAL_LOW;
                        qual_cnt_r <= QW'(1);
                        int_out_r  <= 1'b1;
                        busy_r     <= 1'b1;
                    end else begin
                        int_out_r <= 1'b1;
                        busy_r    <= 1'b0;
                    end
                end
                QUAL_LOW: begin
                    if (glitch_s) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else if (accept_s) begin
                        state_r       <= ASSERT;
                        stretch_cnt_r <= {SW{1'b0}};
                        int_out_r     <= 1'b0;
                    end else begin
                        qual_cnt_r <= qual_cnt_r + QW'(1);
                    end
                end
                ASSERT: begin
                    if ((stretch_cnt_r == STRETCH_MAX) && s_in_s) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            // The exit sample is already the only high sample needed.
                            state_r   <= IDLE;
                            int_out_r <= 1'b1;
                            busy_r    <= 1'b0;
                        end else begin
                            state_r    <= QUAL_HIGH;
                            qual_cnt_r <= QW'(1);
                        end
                    end else if (stretch_cnt_r != STRETCH_MAX) begin
                        stretch_cnt_r <= stretch_cnt_r + SW'(1);
                    end else begin
                        // Held past the stretch: stay low until release is seen.
                        stretch_cnt_r <= stretch_cnt_r;
                    end
                end
                QUAL_HIGH: begin
                    if (!s_in_s) begin
                        // Release bounce restarts high qualification, no new event.
                        qual_cnt_r <= {QW{1'b0}};
                    end else if (qual_cnt_r == QUAL_LAST) begin
                        state_r   <= IDLE;
                        int_out_r <= 1'b1;
                        busy_r    <= 1'b0;
                    end else begin
                        qual_cnt_r <= qual_cnt_r + QW'(1);
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    int_out_r <= 1'b1;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    // Diagnostic counters: a clear wins over the old value but not over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            event_count_r  <= 16'd0;
            glitch_count_r <= 8'd0;
        end else if (event_count_clr) begin
            event_count_r  <= accept_s ? 16'd1 : 16'd0;
            glitch_count_r <= glitch_s ? 8'd1 : 8'd0;
        end else begin
            if (accept_s) begin
                event_count_r <= event_count_r + 16'd1;
            end
            if (glitch_s && (glitch_count_r != 8'hFF)) begin
                glitch_count_r <= glitch_count_r + 8'd1;
            end
        end
    end

    assign int_out      = int_out_r;
    assign busy         = busy_r;
    assign event_count  = event_count_r;
    assign glitch_count = glitch_count_r;

endmodule

// File: tb/tb_touch_int_conditioner.sv
// Self-checking bench for touch_int_conditioner. A run-length reference model
// (consecutive low/high sample counts and time since the pulse fell) predicts
// int_out, busy and both counters every cycle.
module tb_touch_int_conditioner;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int STR  = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        touch_int_n;
    logic        enable;
    logic        event_count_clr;
    logic        int_out;
    logic        busy;
    logic [15:0] event_count;
    logic [7:0]  glitch_count;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    logic [SYNC-1:0] m_hist;
    bit              m_asserted;
    int              m_low;
    int              m_high;
    int              m_held;
    int              m_ev;
    int              m_gl;

    touch_int_conditioner #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .STRETCH_CYCLES (STR)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .touch_int_n    (touch_int_n),
        .enable         (enable),
        .event_count_clr(event_count_clr),
        .int_out        (int_out),
        .busy           (busy),
        .event_count    (event_count),
        .glitch_count   (glitch_count)
    );

    // 100 MHz system clock
    always #5 clk = ~clk;

    // Advance the model by one clock edge using the inputs present at that edge.
    function automatic void model_edge();
        bit s;
        bit inc_ev;
        bit inc_gl;
        inc_ev = 1'b0;
        inc_gl = 1'b0;
        if (reset) begin
            m_hist     = '1;
            m_asserted = 1'b0;
            m_low      = 0;
            m_high     = 0;
            m_held     = 0;
            m_ev       = 0;
            m_gl       = 0;
            return;
        end
        s      = m_hist[SYNC-1];
        m_hist = {m_hist[SYNC-2:0], touch_int_n};
        if (!enable) begin
            m_asserted = 1'b0;
            m_low      = 0;
            m_high     = 0;
        end else if (!m_asserted) begin
            if (!s) begin
                m_low = m_low + 1;
                if (m_low == DEB) begin
                    m_asserted = 1'b1;
                    inc_ev     = 1'b1;
                    m_held     = 0;
                    m_high     = 0;
                    m_low      = 0;
                end
            end else begin
                if (m_low > 0) inc_gl = 1'b1;
                m_low = 0;
            end
        end else begin
            m_held = m_held + 1;
            // Release samples only count once the stretch time has elapsed.
            if (m_held > STR) begin
                if (s) m_high = m_high + 1;
                else   m_high = 0;
            end
            if (m_high == DEB) begin
                m_asserted = 1'b0;
                m_high     = 0;
            end
        end
        if (event_count_clr) begin
            m_ev = 0;
            m_gl = 0;
        end
        if (inc_ev) m_ev = (m_ev + 1) % 65536;
        if (inc_gl && m_gl < 255) m_gl = m_gl + 1;
    endfunction

    function automatic logic [25:0] exp_vec();
        return {~m_asserted, (m_asserted || (m_low > 0)), m_ev[15:0], m_gl[7:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic apply_reset();
        reset           = 1'b1;
        enable          = 1'b1;
        event_count_clr = 1'b0;
        touch_int_n     = 1'b1;
        tick();
        reset = 1'b0;
        repeat (4) tick();
    endtask

    task automatic press(input int low_len, input int high_len);
        touch_int_n = 1'b0;
        repeat (low_len) tick();
        touch_int_n = 1'b1;
        repeat (high_len) tick();
    endtask

    task automatic test_reset();
        reset           = 1'b1;
        enable          = 1'b1;
        event_count_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            touch_int_n = i[0];
            tick();
            tests_run++;
            if ({int_out, busy, event_count, glitch_count} !== {1'b1, 1'b0, 16'd0, 8'd0}) begin
                tests_failed++;
                $display("FAIL reset_hold[%0d]: got int_out=%b busy=%b ev=%0d gl=%0d, want 1 0 0 0",
                         i, int_out, busy, event_count, glitch_count);
            end
        end
        reset       = 1'b0;
        touch_int_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if ({int_out, busy, event_count, glitch_count} !== {1'b1, 1'b0, 16'd0, 8'd0}) begin
                tests_failed++;
                $display("FAIL reset_after[%0d]: got int_out=%b busy=%b ev=%0d gl=%0d, want 1 0 0 0",
                         i, int_out, busy, event_count, glitch_count);
            end
        end
    endtask

    task automatic test_clean_press();
        int fall_at;
        int rise_at;
        apply_reset();
        fall_at     = -1;
        rise_at     = -1;
        touch_int_n = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (i == 30) touch_int_n = 1'b1;
            tick();
            if (fall_at < 0 && int_out === 1'b0) fall_at = i;
            if (fall_at >= 0 && rise_at < 0 && int_out === 1'b1) rise_at = i;
            tests_run++;
            if ({int_out, busy, event_count, glitch_count} !== exp_vec()) begin
                tests_failed++;
                $display("FAIL clean_press_model[%0d]: got %h want %h", i,
                         {int_out, busy, event_count, glitch_count}, exp_vec());
            end
        end
        tests_run++;
        if (fall_at !== 5) begin
            tests_failed++;
            $display("FAIL clean_press_latency: got edge %0d want 5", fall_at);
        end
        tests_run++;
        if (rise_at !== 35) begin
            tests_failed++;
            $display("FAIL clean_press_release: got edge %0d want 35", rise_at);
        end
        tests_run++;
        if (event_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL clean_press_count: got %0d want 1", event_count);
        end
    endtask

    task automatic test_glitch();
        bit went_low;
        apply_reset();
        went_low = 1'b0;
        for (int g = 0; g < 300; g++) begin
            int lo;
            int hi;
            lo = (g == 0) ? 3 : int'($urandom_range(1, 3));
            hi = (g == 0) ? 5 : int'($urandom_range(1, 5));
            touch_int_n = 1'b0;
            for (int c = 0; c < lo + hi; c++) begin
                if (c == lo) touch_int_n = 1'b1;
                tick();
                if (int_out !== 1'b1) went_low = 1'b1;
                tests_run++;
                if ({int_out, busy, event_count, glitch_count} !== exp_vec()) begin
                    tests_failed++;
                    $display("FAIL glitch_model[%0d.%0d]: got %h want %h", g, c,
                             {int_out, busy, event_count, glitch_count}, exp_vec());
                end
            end
            if (g == 0) begin
                tests_run++;
                if ({event_count, glitch_count} !== {16'd0, 8'd1}) begin
                    tests_failed++;
                    $display("FAIL glitch_first: got ev=%0d gl=%0d want ev=0 gl=1",
                             event_count, glitch_count);
                end
            end
        end
        repeat (4) tick();
        tests_run++;
        if ({event_count, glitch_count} !== {16'd0, 8'd255}) begin
            tests_failed++;
            $display("FAIL glitch_saturate: got ev=%0d gl=%0d want ev=0 gl=255",
                     event_count, glitch_count);
        end
        tests_run++;
        if (went_low !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch_int_out: got int_out low during glitches, want always high");
        end
    endtask

    task automatic test_short_press();
        int low_cycles;
        int falls;
        logic prev;
        apply_reset();
        low_cycles  = 0;
        falls       = 0;
        prev        = int_out;
        touch_int_n = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 5) touch_int_n = 1'b1;
            tick();
            if (int_out === 1'b0) low_cycles++;
            if (prev === 1'b1 && int_out === 1'b0) falls++;
            prev = int_out;
            tests_run++;
            if ({int_out, busy, event_count, glitch_count} !== exp_vec()) begin
                tests_failed++;
                $display("FAIL short_press_model[%0d]: got %h want %h", i,
                         {int_out, busy, event_count, glitch_count}, exp_vec());
            end
        end
        tests_run++;
        if (low_cycles !== STR + DEB) begin
            tests_failed++;
            $display("FAIL short_press_width: got %0d cycles want %0d", low_cycles, STR + DEB);
        end
        tests_run++;
        if (falls !== 1) begin
            tests_failed++;
            $display("FAIL short_press_capture: got %0d falling edges want 1", falls);
        end
        tests_run++;
        if (event_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL short_press_count: got %0d want 1", event_count);
        end
    endtask

    task automatic test_release_bounce();
        int rises;
        int rise_at;
        logic prev;
        apply_reset();
        rises       = 0;
        rise_at     = -1;
        prev        = int_out;
        touch_int_n = 1'b0;
        for (int i = 0; i < 45; i++) begin
            if (i == 20) touch_int_n = 1'b1;
            if (i == 22) touch_int_n = 1'b0;
            if (i == 24) touch_int_n = 1'b1;
            tick();
            if (prev === 1'b0 && int_out === 1'b1) begin
                rises++;
                rise_at = i;
            end
            prev = int_out;
            tests_run++;
            if ({int_out, busy, event_count, glitch_count} !== exp_vec()) begin
                tests_failed++;
                $display("FAIL bounce_model[%0d]: got %h want %h", i,
                         {int_out, busy, event_count, glitch_count}, exp_vec());
            end
        end
        tests_run++;
        if (rises !== 1 || rise_at !== 29) begin
            tests_failed++;
            $display("FAIL bounce_rise: got %0d rises last at %0d want 1 at 29", rises, rise_at);
        end
        tests_run++;
        if (event_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL bounce_count: got %0d want 1", event_count);
        end
    endtask

    task automatic test_clr_on_accept();
        apply_reset();
        repeat (5) press(6, 20);
        press(2, 6);
        tests_run++;
        if ({event_count, glitch_count} !== {16'd5, 8'd1}) begin
            tests_failed++;
            $display("FAIL clr_setup: got ev=%0d gl=%0d want ev=5 gl=1", event_count, glitch_count);
        end
        touch_int_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            event_count_clr = (i == 5);
            tick();
        end
        event_count_clr = 1'b0;
        tests_run++;
        if ({int_out, event_count, glitch_count} !== {1'b0, 16'd1, 8'd0}) begin
            tests_failed++;
            $display("FAIL clr_on_accept: got int_out=%b ev=%0d gl=%0d want 0 1 0",
                     int_out, event_count, glitch_count);
        end
        touch_int_n = 1'b1;
        repeat (20) tick();
    endtask

    task automatic test_enable_abort();
        apply_reset();
        press(6, 20);
        press(2, 6);
        touch_int_n = 1'b0;
        for (int i = 0; i < 16; i++) begin
            enable = !(i >= 8 && i <= 12);
            if (i == 9) touch_int_n = 1'b1;
            tick();
            if (i == 7) begin
                tests_run++;
                if (int_out !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL enable_pre: got int_out=%b want 0", int_out);
                end
            end
            if (i == 8) begin
                tests_run++;
                if ({int_out, busy, event_count, glitch_count} !== {1'b1, 1'b0, 16'd2, 8'd1}) begin
                    tests_failed++;
                    $display("FAIL enable_abort: got int_out=%b busy=%b ev=%0d gl=%0d want 1 0 2 1",
                             int_out, busy, event_count, glitch_count);
                end
            end
            tests_run++;
            if ({int_out, busy, event_count, glitch_count} !== exp_vec()) begin
                tests_failed++;
                $display("FAIL enable_model[%0d]: got %h want %h", i,
                         {int_out, busy, event_count, glitch_count}, exp_vec());
            end
        end
        enable = 1'b1;
    endtask

    task automatic test_random();
        int run_left;
        apply_reset();
        run_left = 0;
        for (int i = 0; i < 4000; i++) begin
            if (run_left == 0) begin
                touch_int_n = ~touch_int_n;
                run_left    = int'($urandom_range(1, 25));
            end
            run_left--;
            enable          = (($urandom % 64) != 0);
            event_count_clr = (($urandom % 128) == 0);
            reset           = (($urandom % 700) == 0);
            tick();
            tests_run++;
            if ({int_out, busy, event_count, glitch_count} !== exp_vec()) begin
                tests_failed++;
                $display("FAIL random_model[%0d]: got %h want %h", i,
                         {int_out, busy, event_count, glitch_count}, exp_vec());
            end
        end
        reset           = 1'b0;
        enable          = 1'b1;
        event_count_clr = 1'b0;
    endtask

    // Test sequence
    initial begin
        reset           = 1'b1;
        enable          = 1'b1;
        event_count_clr = 1'b0;
        touch_int_n     = 1'b1;
        test_reset();
        test_clean_press();
        test_glitch();
        test_short_press();
        test_release_bounce();
        test_clr_on_accept();
        test_enable_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
